// File: rtl/img_pkg.sv
// Shared image-pipeline package.
// Holds the default frame geometry used by the line buffers, the median
// filter and the detection stages, the default foreground threshold, and
// helpers that derive coordinate and counter widths from the geometry.
package img_pkg;

    localparam int IMG_COL_DEF   = 1280;
    localparam int IMG_ROW_DEF   = 720;
    localparam int FG_THRESH_DEF = 128;

    // Width needed to hold a coordinate in 0 .. n-1 (never narrower than 1 bit).
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width needed to hold a pixel count in 0 .. cols*rows inclusive.
    function automatic int count_width(input int cols, input int rows);
        return $clog2(cols * rows + 1);
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster coordinate tracker.
// Advances (col,row) once per valid pixel and flags the final pixel of a frame.
// Ports:
//   clk, rst_n      pixel clock, asynchronous active-low reset
//   in_de           pixel valid; counters hold while low
//   col, row        coordinate of the pixel currently presented on in_de
//   last_pix        combinational: in_de on the bottom-right pixel of the frame
module pixel_coord_counter
    import img_pkg::*;
#(
    parameter  int IMG_COL = IMG_COL_DEF,
    parameter  int IMG_ROW = IMG_ROW_DEF,
    localparam int XW      = coord_width(IMG_COL),
    localparam int YW      = coord_width(IMG_ROW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_de,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          last_pix
);

    localparam logic [XW-1:0] COL_LAST = XW'(IMG_COL - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(IMG_ROW - 1);

    logic [XW-1:0] col_r;
    logic [YW-1:0] row_r;
    logic [XW-1:0] col_nxt_s;
    logic [YW-1:0] row_nxt_s;
    logic          last_pix_s;

    // Next-coordinate logic: wrap the column at end of line, the row at end of frame.
    always_comb begin
        col_nxt_s  = col_r;
        row_nxt_s  = row_r;
        last_pix_s = 1'b0;
        if (in_de) begin
            last_pix_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
            if (col_r == COL_LAST) begin
                col_nxt_s = {XW{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_nxt_s = {YW{1'b0}};
                end else begin
                    row_nxt_s = row_r + YW'(1);
                end
            end else begin
                col_nxt_s = col_r + XW'(1);
                row_nxt_s = row_r;
            end
        end else begin
            col_nxt_s  = col_r;
            row_nxt_s  = row_r;
            last_pix_s = 1'b0;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {XW{1'b0}};
            row_r <= {YW{1'b0}};
        end else begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    assign col      = col_r;
    assign row      = row_r;
    assign last_pix = last_pix_s;

endmodule

// File: rtl/face_bbox_detect.sv
// Face bounding-box detector.
// Thresholds the filtered skin mask, accumulates the bounding box and
// foreground pixel count over a frame and publishes a registered result once
// per frame, one cycle after the frame's last pixel.
// Ports:
//   clk, rst_n            pixel clock, asynchronous active-low reset
//   in_de, in_data        filtered mask pixel stream (one pixel per clk when in_de)
//   box_valid             one-cycle pulse when a new frame result is committed
//   box_found             committed frame reached MIN_PIX foreground pixels
//   x_min/x_max/y_min/y_max  committed box (all zero when no face was found)
//   fg_count              true foreground pixel count of the committed frame
module face_bbox_detect
    import img_pkg::*;
#(
    parameter  int IMG_COL   = IMG_COL_DEF,
    parameter  int IMG_ROW   = IMG_ROW_DEF,
    parameter  int FG_THRESH = FG_THRESH_DEF,
    parameter  int MIN_PIX   = 256,
    localparam int XW        = coord_width(IMG_COL),
    localparam int YW        = coord_width(IMG_ROW),
    localparam int CW        = count_width(IMG_COL, IMG_ROW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_de,
    input  logic [7:0]    in_data,
    output logic          box_valid,
    output logic          box_found,
    output logic [XW-1:0] x_min,
    output logic [XW-1:0] x_max,
    output logic [YW-1:0] y_min,
    output logic [YW-1:0] y_max,
    output logic [CW-1:0] fg_count
);

    localparam logic [7:0]    THRESH   = 8'(FG_THRESH);
    localparam logic [CW-1:0] MIN_CNT  = CW'(MIN_PIX);
    localparam logic [XW-1:0] XMIN_INIT = XW'(IMG_COL - 1);
    localparam logic [YW-1:0] YMIN_INIT = YW'(IMG_ROW - 1);

    logic [XW-1:0] col_s;
    logic [YW-1:0] row_s;
    logic          last_pix_s;

    pixel_coord_counter #(
        .IMG_COL (IMG_COL),
        .IMG_ROW (IMG_ROW)
    ) u_coord (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_de    (in_de),
        .col      (col_s),
        .row      (row_s),
        .last_pix (last_pix_s)
    );

    // Running (in-frame) accumulators.
    logic [XW-1:0] rx_min_r, rx_max_r;
    logic [YW-1:0] ry_min_r, ry_max_r;
    logic [CW-1:0] rcnt_r;

    // Accumulators merged with the current pixel; feeds both the running
    // registers and the commit path so the last pixel is never lost.
    logic          fg_s;
    logic [XW-1:0] mx_min_s, mx_max_s;
    logic [YW-1:0] my_min_s, my_max_s;
    logic [CW-1:0] mcnt_s;

    // Next-state values.
    logic [XW-1:0] rx_min_nxt_s, rx_max_nxt_s;
    logic [YW-1:0] ry_min_nxt_s, ry_max_nxt_s;
    logic [CW-1:0] rcnt_nxt_s;
    logic          box_valid_nxt_s, box_found_nxt_s;
    logic [XW-1:0] x_min_nxt_s, x_max_nxt_s;
    logic [YW-1:0] y_min_nxt_s, y_max_nxt_s;
    logic [CW-1:0] fg_count_nxt_s;

    logic          box_valid_r, box_found_r;
    logic [XW-1:0] x_min_r, x_max_r;
    logic [YW-1:0] y_min_r, y_max_r;
    logic [CW-1:0] fg_count_r;

    // Foreground decision and merge of the current pixel into the accumulators.
    always_comb begin
        fg_s     = 1'b0;
        mx_min_s = rx_min_r;
        mx_max_s = rx_max_r;
        my_min_s = ry_min_r;
        my_max_s = ry_max_r;
        mcnt_s   = rcnt_r;
        if (in_de && (in_data >= THRESH)) begin
            fg_s     = 1'b1;
            mx_min_s = (col_s < rx_min_r) ? col_s : rx_min_r;
            mx_max_s = (col_s > rx_max_r) ? col_s : rx_max_r;
            my_min_s = (row_s < ry_min_r) ? row_s : ry_min_r;
            my_max_s = (row_s > ry_max_r) ? row_s : ry_max_r;
            mcnt_s   = rcnt_r + CW'(1);
        end else begin
            fg_s     = 1'b0;
        end
    end

    // Running registers restart on the commit cycle so a back-to-back frame
    // starts clean on the following pixel.
    always_comb begin
        rx_min_nxt_s = mx_min_s;
        rx_max_nxt_s = mx_max_s;
        ry_min_nxt_s = my_min_s;
        ry_max_nxt_s = my_max_s;
        rcnt_nxt_s   = mcnt_s;
        if (last_pix_s) begin
            rx_min_nxt_s = XMIN_INIT;
            rx_max_nxt_s = {XW{1'b0}};
            ry_min_nxt_s = YMIN_INIT;
            ry_max_nxt_s = {YW{1'b0}};
            rcnt_nxt_s   = {CW{1'b0}};
        end else begin
            rx_min_nxt_s = mx_min_s;
            rx_max_nxt_s = mx_max_s;
            ry_min_nxt_s = my_min_s;
            ry_max_nxt_s = my_max_s;
            rcnt_nxt_s   = mcnt_s;
        end
    end

    // Commit path: publish the merged result on the last pixel, otherwise hold.
    always_comb begin
        box_valid_nxt_s = 1'b0;
        box_found_nxt_s = box_found_r;
        x_min_nxt_s     = x_min_r;
        x_max_nxt_s     = x_max_r;
        y_min_nxt_s     = y_min_r;
        y_max_nxt_s     = y_max_r;
        fg_count_nxt_s  = fg_count_r;
        if (last_pix_s) begin
            box_valid_nxt_s = 1'b1;
            fg_count_nxt_s  = mcnt_s;
            if (mcnt_s >= MIN_CNT) begin
                box_found_nxt_s = 1'b1;
                x_min_nxt_s     = mx_min_s;
                x_max_nxt_s     = mx_max_s;
                y_min_nxt_s     = my_min_s;
                y_max_nxt_s     = my_max_s;
            end else begin
                box_found_nxt_s = 1'b0;
                x_min_nxt_s     = {XW{1'b0}};
                x_max_nxt_s     = {XW{1'b0}};
                y_min_nxt_s     = {YW{1'b0}};
                y_max_nxt_s     = {YW{1'b0}};
            end
        end else begin
            box_valid_nxt_s = 1'b0;
        end
    end

    // Running accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_min_r <= XMIN_INIT;
            rx_max_r <= {XW{1'b0}};
            ry_min_r <= YMIN_INIT;
            ry_max_r <= {YW{1'b0}};
            rcnt_r   <= {CW{1'b0}};
        end else begin
            rx_min_r <= rx_min_nxt_s;
            rx_max_r <= rx_max_nxt_s;
            ry_min_r <= ry_min_nxt_s;
            ry_max_r <= ry_max_nxt_s;
            rcnt_r   <= rcnt_nxt_s;
        end
    end

    // Committed result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_valid_r <= 1'b0;
            box_found_r <= 1'b0;
            x_min_r     <= {XW{1'b0}};
            x_max_r     <= {XW{1'b0}};
            y_min_r     <= {YW{1'b0}};
            y_max_r     <= {YW{1'b0}};
            fg_count_r  <= {CW{1'b0}};
        end else begin
            box_valid_r <= box_valid_nxt_s;
            box_found_r <= box_found_nxt_s;
            x_min_r     <= x_min_nxt_s;
            x_max_r     <= x_max_nxt_s;
            y_min_r     <= y_min_nxt_s;
            y_max_r     <= y_max_nxt_s;
            fg_count_r  <= fg_count_nxt_s;
        end
    end

    assign box_valid = box_valid_r;
    assign box_found = box_found_r;
    assign x_min     = x_min_r;
    assign x_max     = x_max_r;
    assign y_min     = y_min_r;
    assign y_max     = y_max_r;
    assign fg_count  = fg_count_r;

endmodule

// File: tb/tb_face_bbox_detect.sv
// Self-checking bench for face_bbox_detect on an 8x6 frame with MIN_PIX=2.
// A monitor compares every output on every falling edge against the result
// last committed by the reference expectation queue.
module tb_face_bbox_detect;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;
    localparam int MINP = 2;
    localparam int XW   = $clog2(COLS);
    localparam int YW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS * ROWS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_de;
    logic [7:0]    in_data;
    logic          box_valid, box_found;
    logic [XW-1:0] x_min, x_max;
    logic [YW-1:0] y_min, y_max;
    logic [CW-1:0] fg_count;

    face_bbox_detect #(
        .IMG_COL (COLS),
        .IMG_ROW (ROWS),
        .FG_THRESH (128),
        .MIN_PIX (MINP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_de     (in_de),
        .in_data   (in_data),
        .box_valid (box_valid),
        .box_found (box_found),
        .x_min     (x_min),
        .x_max     (x_max),
        .y_min     (y_min),
        .y_max     (y_max),
        .fg_count  (fg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int found;
        int xmin, xmax, ymin, ymax, cnt;
    } exp_t;

    typedef struct {
        logic [47:0] mask;
        logic [7:0]  fg_val;
        logic [7:0]  bg_val;
        int          max_gap;
        int          found;
        int          xmin, xmax, ymin, ymax, cnt;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    exp_t       hold;
    exp_t       cur_exp;
    logic [7:0] frame_buf[NPIX];
    vec_t       vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Reference: scan the frame as a 2-D image and derive the box from its definition.
    function automatic exp_t model();
        exp_t e;
        int n = 0;
        int x0 = COLS, x1 = -1, y0 = ROWS, y1 = -1;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (frame_buf[r*COLS + c] >= 8'd128) begin
                    n++;
                    if (c < x0) x0 = c;
                    if (c > x1) x1 = c;
                    if (r < y0) y0 = r;
                    if (r > y1) y1 = r;
                end
            end
        end
        e.due = 0;
        e.cnt = n;
        e.found = (n >= MINP) ? 1 : 0;
        e.xmin = e.found ? x0 : 0;
        e.xmax = e.found ? x1 : 0;
        e.ymin = e.found ? y0 : 0;
        e.ymax = e.found ? y1 : 0;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mask(input logic [47:0] m, input logic [7:0] fv, input logic [7:0] bv);
        for (int i = 0; i < NPIX; i++) frame_buf[i] = m[i] ? fv : bv;
    endtask

    // Drive npix pixels of frame_buf with random idle gaps; expect a commit
    // one cycle after the 48th pixel.
    task automatic send_frame(input int max_gap, input int npix);
        for (int i = 0; i < npix; i++) begin
            int g;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int k = 0; k < g; k++) begin
                in_de = 1'b0;
                in_data = 8'hFF;
                step();
            end
            in_de = 1'b1;
            in_data = frame_buf[i];
            if (i == NPIX - 1) begin
                exp_t e;
                e = cur_exp;
                e.due = cyc + 1;
                exp_q.push_back(e);
            end
            step();
        end
        in_de = 1'b0;
        in_data = 8'h00;
    endtask

    // Monitor: pulse timing plus hold-until-next-commit of all outputs.
    initial begin
        hold = '{0, 0, 0, 0, 0, 0, 0};
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                hold = exp_q.pop_front();
                chk("box_valid_pulse", box_valid, 1);
            end else begin
                chk("box_valid_idle", box_valid, 0);
            end
            chk("box_found", box_found, hold.found);
            chk("x_min", x_min, hold.xmin);
            chk("x_max", x_max, hold.xmax);
            chk("y_min", y_min, hold.ymin);
            chk("y_max", y_max, hold.ymax);
            chk("fg_count", fg_count, hold.cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dens[6];
        vecs[0] = '{48'h0000_1C1C_1C00, 8'hFF, 8'h00, 0, 1, 2, 4, 1, 3, 9};
        vecs[1] = '{48'h0000_1C1C_1C00, 8'hFF, 8'h00, 5, 1, 2, 4, 1, 3, 9};
        vecs[2] = '{48'h0000_0000_0000, 8'hFF, 8'h00, 2, 0, 0, 0, 0, 0, 0};
        vecs[3] = '{48'h0000_0020_0000, 8'd128, 8'd127, 1, 0, 0, 0, 0, 0, 1};
        dens = '{0, 2, 5, 30, 60, 100};

        // Reset held with toggling inputs: outputs must stay zero.
        rst_n = 1'b0;
        in_de = 1'b0;
        in_data = 8'h00;
        for (int i = 0; i < 6; i++) begin
            step();
            in_data = ~in_data;
            in_de = ~in_de;
        end
        step();
        in_de = 1'b0;
        rst_n = 1'b1;
        step();

        // Directed frames from the table.
        for (int v = 0; v < 4; v++) begin
            load_mask(vecs[v].mask, vecs[v].fg_val, vecs[v].bg_val);
            cur_exp = '{0, vecs[v].found, vecs[v].xmin, vecs[v].xmax,
                        vecs[v].ymin, vecs[v].ymax, vecs[v].cnt};
            send_frame(vecs[v].max_gap, NPIX);
            repeat (3) step();
        end

        // Back-to-back frames: corners, then a diagonal pair, no idle cycle between.
        load_mask(48'h8000_0000_0001, 8'hFF, 8'h00);
        cur_exp = '{0, 1, 0, 7, 0, 5, 2};
        send_frame(0, NPIX);
        load_mask(48'h0010_0800_0000, 8'hFF, 8'h00);
        cur_exp = '{0, 1, 3, 4, 3, 4, 2};
        send_frame(0, NPIX);

        // Reset after 20 pixels of a frame, then a full frame.
        load_mask(vecs[0].mask, 8'hFF, 8'h00);
        send_frame(0, 20);
        rst_n = 1'b0;
        hold = '{0, 0, 0, 0, 0, 0, 0};
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        cur_exp = '{0, 1, 2, 4, 1, 3, 9};
        send_frame(2, NPIX);
        repeat (2) step();

        // Random frames against the reference model.
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NPIX; i++) begin
                if (int'($urandom_range(99, 0)) < dens[k])
                    frame_buf[i] = 8'($urandom_range(255, 128));
                else
                    frame_buf[i] = 8'($urandom_range(127, 0));
            end
            cur_exp = model();
            send_frame((k % 2 == 1) ? 3 : 0, NPIX);
        end
        repeat (5) step();

        chk("pending_commits", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
